// File: rtl/vga_text_reader.sv
// 80x30 text-mode VGA scan-out: walks the raster, fetches character codes and glyph rows
// through a three-tick pipeline, and drives aligned rgb/hsync/vsync at half the clk rate.
module vga_text_reader #(
    parameter int         H_VIS = 640,
    parameter int         H_FP  = 16,
    parameter int         H_SW  = 96,
    parameter int         H_BP  = 48,
    parameter int         V_VIS = 480,
    parameter int         V_FP  = 10,
    parameter int         V_SW  = 2,
    parameter int         V_BP  = 33,
    parameter logic [7:0] FG    = 8'hFF,
    parameter logic [7:0] BG    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  vgaData_IN,
    input  logic [7:0]  glyphData_IN,
    output logic [13:0] vgaAddr,
    output logic [10:0] glyphAddr,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  rgb,
    output logic        frameStart
);

    localparam int H_TOT    = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SW + V_BP;
    localparam int HS_FIRST = H_VIS + H_FP;
    localparam int HS_LAST  = H_VIS + H_FP + H_SW - 1;
    localparam int VS_FIRST = V_VIS + V_FP;
    localparam int VS_LAST  = V_VIS + V_FP + V_SW - 1;
    localparam logic [13:0] CELL_COLS = 14'd80;

    logic        tick_q;
    logic        pix_tick;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        visible;
    logic        hs_raw;
    logic        vs_raw;
    logic [13:0] cell_idx;

    // stage 1 -> 2 side-band
    logic        vis_d1, hs_d1, vs_d1, first_d1;
    logic [3:0]  row_d1;
    logic [2:0]  col_d1;
    // stage 2 -> 3 side-band
    logic        vis_d2, hs_d2, vs_d2, first_d2;
    logic [2:0]  col_d2;
    logic        vis_d3;

    // The tick is high on the first edge after reset release, so pixel (0,0) is processed there.
    assign pix_tick = ~tick_q;

    always_comb begin
        visible  = (int'(hcount) < H_VIS) && (int'(vcount) < V_VIS);
        hs_raw   = !((int'(hcount) >= HS_FIRST) && (int'(hcount) <= HS_LAST));
        vs_raw   = !((int'(vcount) >= VS_FIRST) && (int'(vcount) <= VS_LAST));
        cell_idx = 14'(vcount[9:4]) * CELL_COLS + 14'(hcount[9:3]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q     <= 1'b0;
            hcount     <= '0;
            vcount     <= '0;
            vgaAddr    <= '0;
            glyphAddr  <= '0;
            rgb        <= 8'h00;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frameStart <= 1'b0;
            vis_d1     <= 1'b0;
            hs_d1      <= 1'b1;
            vs_d1      <= 1'b1;
            first_d1   <= 1'b0;
            row_d1     <= '0;
            col_d1     <= '0;
            vis_d2     <= 1'b0;
            hs_d2      <= 1'b1;
            vs_d2      <= 1'b1;
            first_d2   <= 1'b0;
            col_d2     <= '0;
            vis_d3     <= 1'b0;
        end else begin
            tick_q     <= ~tick_q;
            frameStart <= 1'b0;
            if (pix_tick) begin
                if (hcount == 10'(H_TOT - 1)) begin
                    hcount <= '0;
                    vcount <= (vcount == 10'(V_TOT - 1)) ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end

                // stage 1: address VGA memory; hold the last address through blanking
                if (visible)
                    vgaAddr <= cell_idx;
                vis_d1   <= visible;
                hs_d1    <= hs_raw;
                vs_d1    <= vs_raw;
                first_d1 <= (hcount == '0) && (vcount == '0);
                row_d1   <= vcount[3:0];
                col_d1   <= hcount[2:0];

                // stage 2: character code arrives, address the glyph ROM
                glyphAddr <= {vgaData_IN, row_d1};
                vis_d2    <= vis_d1;
                hs_d2     <= hs_d1;
                vs_d2     <= vs_d1;
                first_d2  <= first_d1;
                col_d2    <= col_d1;

                // stage 3: glyph row arrives, pick the pixel bit
                if (vis_d2)
                    rgb <= glyphData_IN[3'd7 - col_d2] ? FG : BG;
                else
                    rgb <= 8'h00;
                hsync      <= hs_d2;
                vsync      <= vs_d2;
                vis_d3     <= vis_d2;
                frameStart <= first_d2;
            end
        end
    end

    a_blank_black : assert property (@(posedge clk) vis_d3 || (rgb == 8'h00));
    a_addr_range  : assert property (@(posedge clk) vgaAddr <= 14'd2399);

endmodule

// File: tb/tb_vga_text_reader.sv
// Bench for vga_text_reader on a shrunken raster: memory/ROM models plus a per-pixel
// scoreboard that predicts rgb/sync/frameStart three ticks ahead of the DUT.
module tb_vga_text_reader;

    localparam int HV = 128, HFP = 8, HSW = 16, HBP = 8;
    localparam int VV = 40,  VFP = 3, VSW = 2,  VBP = 5;
    localparam int HT = HV + HFP + HSW + HBP;   // 160
    localparam int VT = VV + VFP + VSW + VBP;   // 50
    localparam logic [7:0] FG_T = 8'hE3;
    localparam logic [7:0] BG_T = 8'h1C;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  vga_data;
    logic [7:0]  glyph_data;
    logic [13:0] vgaAddr;
    logic [10:0] glyphAddr;
    logic        hsync, vsync, frameStart;
    logic [7:0]  rgb;

    vga_text_reader #(
        .H_VIS(HV), .H_FP(HFP), .H_SW(HSW), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP),
        .FG(FG_T), .BG(BG_T)
    ) dut (
        .clk(clk), .reset(reset),
        .vgaData_IN(vga_data), .glyphData_IN(glyph_data),
        .vgaAddr(vgaAddr), .glyphAddr(glyphAddr),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frameStart(frameStart)
    );

    always #10 clk = ~clk;

    function automatic logic [6:0] char_of(logic [13:0] a);
        if (a == 14'd0) return 7'h41;
        if (a >= 14'd160 && a < 14'd240) return 7'h7F;
        return 7'((int'(a) * 37 + 11) % 128);
    endfunction

    function automatic logic [7:0] glyph_of(logic [10:0] g);
        if (g == 11'h410) return 8'h81;
        return 8'((int'(g) * 29) ^ (int'(g) >> 2));
    endfunction

    // synchronous memories, one clk read latency
    always @(posedge clk) begin
        vga_data   <= char_of(vgaAddr);
        glyph_data <= glyph_of(glyphAddr);
    end

    typedef struct {
        int         h;
        int         v;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    exp_t pop_e;

    int tests = 0;
    int errors = 0;
    bit tick_phase;
    int mh, mv, last_h, last_v;
    bit ticked, popped;
    logic [13:0] exp_vaddr, prev_vaddr;
    logic [3:0]  prev_row;
    int tick_idx, hs_run, vs_run, last_hfall, last_fs, fs_seen;
    logic prev_hs;

    task automatic model_init();
        sb.delete();
        tick_phase = 1'b0;
        mh = 0; mv = 0; last_h = -1; last_v = -1;
        exp_vaddr = '0; prev_vaddr = '0; prev_row = '0;
        tick_idx = 0; hs_run = 0; vs_run = 0;
        last_hfall = -1; last_fs = -1; prev_hs = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            tests++;
            if (rgb !== 8'h00 || hsync !== 1'b1 || vsync !== 1'b1 || frameStart !== 1'b0 ||
                vgaAddr !== 14'd0 || glyphAddr !== 11'd0) begin
                errors++;
                $display("FAIL reset_values: rgb=%h hs=%b vs=%b fs=%b va=%0d ga=%h, need 00 1 1 0 0 000",
                         rgb, hsync, vsync, frameStart, vgaAddr, glyphAddr);
            end
        end
        reset = 1'b1;
        model_init();
    endtask

    task automatic tick_clk();
        exp_t e;
        logic [7:0] grow;
        logic [10:0] exp_g;
        bit vis;
        @(posedge clk); #1;
        ticked = 1'b0;
        popped = 1'b0;
        if (!tick_phase) begin
            vis   = (mh < HV) && (mv < VV);
            exp_g = {char_of(prev_vaddr), prev_row};
            if (vis) exp_vaddr = 14'((mv / 16) * 80 + mh / 8);
            tests++;
            if (vgaAddr !== exp_vaddr) begin
                errors++;
                $display("FAIL vgaAddr at (%0d,%0d): got %0d need %0d", mh, mv, vgaAddr, exp_vaddr);
            end
            tests++;
            if (glyphAddr !== exp_g) begin
                errors++;
                $display("FAIL glyphAddr at (%0d,%0d): got %h need %h", mh, mv, glyphAddr, exp_g);
            end
            prev_vaddr = exp_vaddr;
            prev_row   = 4'(mv % 16);

            e.h = mh; e.v = mv;
            grow  = glyph_of({char_of(exp_vaddr), 4'(mv % 16)});
            e.rgb = !vis ? 8'h00 : (grow[7 - (mh % 8)] ? FG_T : BG_T);
            e.hs  = !((mh >= HV + HFP) && (mh <= HV + HFP + HSW - 1));
            e.vs  = !((mv >= VV + VFP) && (mv <= VV + VFP + VSW - 1));
            e.fs  = (mh == 0) && (mv == 0);
            sb.push_back(e);

            if (sb.size() == 3) begin
                pop_e  = sb.pop_front();
                popped = 1'b1;
                tests++;
                if (rgb !== pop_e.rgb || hsync !== pop_e.hs || vsync !== pop_e.vs || frameStart !== pop_e.fs) begin
                    errors++;
                    $display("FAIL pixel (%0d,%0d): got rgb=%h hs=%b vs=%b fs=%b need rgb=%h hs=%b vs=%b fs=%b",
                             pop_e.h, pop_e.v, rgb, hsync, vsync, frameStart,
                             pop_e.rgb, pop_e.hs, pop_e.vs, pop_e.fs);
                end
                if (hsync === 1'b0) begin
                    hs_run++;
                    if (prev_hs === 1'b1) begin
                        if (last_hfall >= 0) begin
                            tests++;
                            if (tick_idx - last_hfall != HT) begin
                                errors++;
                                $display("FAIL line_period: got %0d ticks need %0d", tick_idx - last_hfall, HT);
                            end
                        end
                        last_hfall = tick_idx;
                    end
                end else if (hs_run != 0) begin
                    tests++;
                    if (hs_run != HSW) begin
                        errors++;
                        $display("FAIL hsync_width: got %0d ticks need %0d", hs_run, HSW);
                    end
                    hs_run = 0;
                end
                prev_hs = hsync;
                if (vsync === 1'b0) vs_run++;
                else if (vs_run != 0) begin
                    tests++;
                    if (vs_run != VSW * HT) begin
                        errors++;
                        $display("FAIL vsync_width: got %0d ticks need %0d", vs_run, VSW * HT);
                    end
                    vs_run = 0;
                end
                if (frameStart === 1'b1) begin
                    fs_seen++;
                    if (last_fs >= 0) begin
                        tests++;
                        if (tick_idx - last_fs != HT * VT) begin
                            errors++;
                            $display("FAIL frame_period: got %0d ticks need %0d", tick_idx - last_fs, HT * VT);
                        end
                    end
                    last_fs = tick_idx;
                end
            end else begin
                tests++;
                if (rgb !== 8'h00 || hsync !== 1'b1 || vsync !== 1'b1 || frameStart !== 1'b0) begin
                    errors++;
                    $display("FAIL pipe_fill: got rgb=%h hs=%b vs=%b fs=%b need 00 1 1 0",
                             rgb, hsync, vsync, frameStart);
                end
            end
            last_h = mh; last_v = mv;
            ticked = 1'b1;
            tick_idx++;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end else begin
            tests++;
            if (frameStart !== 1'b0) begin
                errors++;
                $display("FAIL fs_one_clk: got %b on off-tick clk need 0", frameStart);
            end
        end
        tick_phase = ~tick_phase;
    endtask

    task automatic run_to(input int h, input int v, input int budget);
        int n = 0;
        do begin
            tick_clk();
            n++;
        end while (!(ticked && last_h == h && last_v == v) && n < budget);
        if (!(ticked && last_h == h && last_v == v)) begin
            tests++;
            errors++;
            $display("FAIL run_to(%0d,%0d): not reached in %0d clk", h, v, budget);
        end
    endtask

    task automatic test_reset();
        do_reset(4);
    endtask

    task automatic test_first_line();
        int n = 0;
        bit done = 0;
        while (!done && n < 400) begin
            tick_clk();
            n++;
            if (popped && pop_e.v == 0 && pop_e.h < 8) begin
                tests++;
                if (rgb !== ((pop_e.h == 0 || pop_e.h == 7) ? FG_T : BG_T)) begin
                    errors++;
                    $display("FAIL first_line px%0d: got %h need %h", pop_e.h, rgb,
                             (pop_e.h == 0 || pop_e.h == 7) ? FG_T : BG_T);
                end
                if (pop_e.h == 7) done = 1;
            end
        end
        if (!done) begin
            tests++;
            errors++;
            $display("FAIL first_line: pixel 7 never emitted");
        end
    endtask

    task automatic test_cell_addr();
        run_to(8, 16, 20000);
        tests++;
        if (vgaAddr !== 14'd81) begin
            errors++;
            $display("FAIL cell_8_16: got %0d need 81", vgaAddr);
        end
        run_to(HV + 2, 16, 1000);
        tests++;
        if (vgaAddr !== 14'd95) begin
            errors++;
            $display("FAIL blank_hold: got %0d need 95", vgaAddr);
        end
    endtask

    task automatic test_glyph_row();
        run_to(0, 35, 20000);
        tick_clk();
        tick_clk();
        tests++;
        if (glyphAddr !== 11'h7F3) begin
            errors++;
            $display("FAIL glyph_row3: got %h need 7f3", glyphAddr);
        end
    endtask

    task automatic test_frames();
        int n = 0;
        while (fs_seen < 3 && n < 40000) begin
            tick_clk();
            n++;
        end
        tests++;
        if (fs_seen < 3) begin
            errors++;
            $display("FAIL frames: got %0d frameStart pulses need 3", fs_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        int first = -1;
        run_to(100, 20, 20000);
        do_reset(3);
        for (int i = 1; i <= 10; i++) begin
            tick_clk();
            if (frameStart === 1'b1 && first < 0) first = i;
        end
        tests++;
        if (first != 5) begin
            errors++;
            $display("FAIL restart_fs: got first frameStart at clk %0d need 5", first);
        end
    endtask

    initial begin
        reset = 1'b0;
        fs_seen = 0;
        model_init();
        test_reset();
        test_first_line();
        test_cell_addr();
        test_glyph_row();
        test_frames();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
